// File: rtl/chess_turn_ctrl.sv
// Chess clock control stage: button synchronise/debounce, turn FSM and 1 Hz prescaler
// that steers count-enable ticks to the active player's counter.
module chess_turn_ctrl #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int TICK_HZ         = 1,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic in_clk,
    input  logic reset,
    input  logic btn_left_n,
    input  logic btn_right_n,
    input  logic btn_clr_n,
    input  logic pause,
    output logic tick_a,
    output logic tick_b,
    output logic clear_pulse,
    output logic active_b,
    output logic running
);
    // state | meaning
    // IDLE  | no clock running; waiting for the first player to hit their button
    // RUN_A | player A's clock counts
    // RUN_B | player B's clock counts

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PS_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PS_W-1:0] TICK_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN_A, RUN_B} state_t;

    logic [2:0]      raw_n;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      stable;
    logic [2:0]      press;
    logic [DB_W-1:0] db_cnt [3];

    assign raw_n = {btn_clr_n, btn_right_n, btn_left_n};

    // index 0 = left, 1 = right, 2 = clear; a press is a debounced 1->0 of stable
    always_ff @(posedge in_clk) begin
        if (reset) begin
            sync1  <= '1;
            sync2  <= '1;
            stable <= '1;
            press  <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw_n;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] != stable[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        stable[i] <= sync2[i];
                        db_cnt[i] <= '0;
                        press[i]  <= ~sync2[i];
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    logic            left_evt;
    logic            right_evt;
    logic            clr_evt;
    logic            turn_change;
    state_t          state;
    state_t          state_nxt;
    logic [PS_W-1:0] presc;

    assign left_evt  = press[0];
    assign right_evt = press[1];
    assign clr_evt   = press[2];

    always_comb begin
        state_nxt = state;
        if (clr_evt) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (left_evt && !right_evt)      state_nxt = RUN_B;
                    else if (right_evt && !left_evt) state_nxt = RUN_A;
                end
                RUN_A:   if (right_evt) state_nxt = RUN_B;
                RUN_B:   if (left_evt)  state_nxt = RUN_A;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // clear counts as a transition even from IDLE so the prescaler is always zeroed
    assign turn_change = clr_evt || (state_nxt != state);

    always_ff @(posedge in_clk) begin
        if (reset) begin
            state       <= IDLE;
            presc       <= '0;
            tick_a      <= 1'b0;
            tick_b      <= 1'b0;
            clear_pulse <= 1'b0;
            active_b    <= 1'b0;
            running     <= 1'b0;
        end else begin
            state       <= state_nxt;
            clear_pulse <= clr_evt;
            running     <= (state_nxt != IDLE);
            tick_a      <= 1'b0;
            tick_b      <= 1'b0;
            if (state_nxt == RUN_B)
                active_b <= 1'b1;
            else if (state_nxt == RUN_A || clr_evt)
                active_b <= 1'b0;

            // a switch on the terminal cycle wins over the tick
            if (turn_change) begin
                presc <= '0;
            end else if (state != IDLE && !pause) begin
                if (presc == TICK_LAST) begin
                    presc  <= '0;
                    tick_a <= (state == RUN_A);
                    tick_b <= (state == RUN_B);
                end else begin
                    presc <= presc + PS_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_chess_turn_ctrl.sv
// Scoreboard bench for chess_turn_ctrl: expected tick/clear pulses are queued with the
// cycle they must appear in and matched as the DUT emits them.
module tb_chess_turn_ctrl;
    localparam int K_TA  = 1;
    localparam int K_TB  = 2;
    localparam int K_CLR = 4;

    logic in_clk = 1'b0;
    logic reset;
    logic btn_left_n, btn_right_n, btn_clr_n, pause;
    logic tick_a, tick_b, clear_pulse, active_b, running;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc     = 0;
    int   n_check = 0;
    int   n_err   = 0;

    chess_turn_ctrl #(
        .CLK_HZ          (20),
        .TICK_HZ         (1),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .in_clk      (in_clk),
        .reset       (reset),
        .btn_left_n  (btn_left_n),
        .btn_right_n (btn_right_n),
        .btn_clr_n   (btn_clr_n),
        .pause       (pause),
        .tick_a      (tick_a),
        .tick_b      (tick_b),
        .clear_pulse (clear_pulse),
        .active_b    (active_b),
        .running     (running)
    );

    always #5 in_clk = ~in_clk;

    always @(posedge in_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_check++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        sbq.push_back(e);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge in_clk);
    endtask

    // every tick/clear pulse must match the head of the scoreboard
    always @(negedge in_clk) begin
        int   kind;
        exp_t e;
        kind = {29'd0, clear_pulse, tick_b, tick_a};
        if (kind != 0) begin
            if (sbq.size() == 0) begin
                chk("unexpected_pulse", kind, 0);
            end else begin
                e = sbq.pop_front();
                chk("pulse_kind", kind, e.kind);
                chk("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int n, e0, s1, b0, a0, r0;
        reset       = 1'b1;
        btn_left_n  = 1'b1;
        btn_right_n = 1'b1;
        btn_clr_n   = 1'b1;
        pause       = 1'b0;
        repeat (3) @(negedge in_clk);
        chk("reset_outputs", {tick_a, tick_b, clear_pulse, active_b, running}, 0);
        reset = 1'b0;
        repeat (2) @(negedge in_clk);

        // bounced left press from IDLE
        btn_left_n = 1'b0;
        @(negedge in_clk);
        btn_left_n = 1'b1;
        @(negedge in_clk);
        btn_left_n = 1'b0;
        n  = cyc;
        e0 = n + 7;
        for (int k = 1; k <= 6; k++) push(K_TB, e0 + 20 * k);
        wait_to(n + 6);
        chk("t1_not_yet_running", running, 0);
        wait_to(e0);
        chk("t1_running", running, 1);
        chk("t1_active_b", active_b, 1);
        wait_to(n + 10);
        btn_left_n = 1'b1;

        // right press in RUN_B is ignored
        wait_to(e0 + 105);
        btn_right_n = 1'b0;
        wait_to(e0 + 115);
        btn_right_n = 1'b1;
        chk("t3_still_b", active_b, 1);

        // left switches to RUN_A and restarts the prescaler
        wait_to(e0 + 125);
        btn_left_n = 1'b0;
        s1 = e0 + 132;
        push(K_TA, s1 + 20);
        wait_to(s1);
        chk("t3_active_a", active_b, 0);
        chk("t3_running", running, 1);
        wait_to(s1 + 3);
        btn_left_n = 1'b1;

        // back to RUN_B, then left lands on the terminal cycle
        wait_to(s1 + 25);
        btn_right_n = 1'b0;
        b0 = s1 + 32;
        wait_to(b0);
        chk("t4_enter_b", active_b, 1);
        wait_to(b0 + 3);
        btn_right_n = 1'b1;
        wait_to(b0 + 13);
        btn_left_n = 1'b0;
        a0 = b0 + 20;
        push(K_TA, a0 + 20);
        wait_to(a0);
        chk("t4_state_a", active_b, 0);
        chk("t4_running", running, 1);
        wait_to(a0 + 3);
        btn_left_n = 1'b1;

        // pause at count 12 for 50 cycles
        wait_to(a0 + 32);
        pause = 1'b1;
        wait_to(a0 + 82);
        chk("t5_paused_running", running, 1);
        pause = 1'b0;
        push(K_TA, a0 + 90);

        // clear and left together
        wait_to(a0 + 95);
        btn_left_n = 1'b0;
        btn_clr_n  = 1'b0;
        push(K_CLR, a0 + 102);
        wait_to(a0 + 101);
        chk("t6_pre_clear_running", running, 1);
        wait_to(a0 + 102);
        chk("t6_idle", running, 0);
        chk("t6_active_b", active_b, 0);
        wait_to(a0 + 105);
        btn_left_n = 1'b1;
        btn_clr_n  = 1'b1;

        // reset mid-run discards the partial count
        r0 = a0 + 115;
        wait_to(r0);
        btn_right_n = 1'b0;
        wait_to(r0 + 7);
        chk("t6_run_a", running, 1);
        wait_to(r0 + 10);
        btn_right_n = 1'b1;
        wait_to(r0 + 22);
        reset = 1'b1;
        wait_to(r0 + 23);
        chk("t6_reset_outputs", {tick_a, tick_b, clear_pulse, active_b, running}, 0);
        wait_to(r0 + 24);
        reset = 1'b0;

        // both players in the same cycle from IDLE
        wait_to(r0 + 30);
        btn_left_n  = 1'b0;
        btn_right_n = 1'b0;
        wait_to(r0 + 38);
        chk("both_stay_idle", running, 0);
        wait_to(r0 + 40);
        btn_left_n  = 1'b1;
        btn_right_n = 1'b1;
        wait_to(r0 + 70);
        chk("both_still_idle", running, 0);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_check, n_err);
        $finish;
    end
endmodule
